// File: rtl/game_flow_ctrl.sv
// Game-level sequencer for the 8x8 LED brick-breaker: serve/play/pause flow, lives,
// BCD score and level-dependent ball pacing. All outputs are registered.
module game_flow_ctrl #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned STEP_DIV_INIT = 3,
    parameter int unsigned STEP_DIV_MIN  = 1,
    parameter int unsigned PAUSE_TICKS   = 20,
    parameter int unsigned MAX_LEVEL     = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       throw_btn_i,
    input  logic       brick_hit_i,
    input  logic       ball_lost_i,
    input  logic [4:0] bricks_left_i,
    output logic       engine_clr_o,
    output logic       serve_rst_o,
    output logic       serve_hold_o,
    output logic       ball_step_o,
    output logic [1:0] lives_o,
    output logic [7:0] score_o,
    output logic [1:0] level_o,
    output logic [2:0] state_o,
    output logic       game_over_o
);

    localparam int unsigned DivW   = $clog2(STEP_DIV_INIT + 1);
    localparam int unsigned PauseW = $clog2(PAUSE_TICKS + 1);

    localparam logic [1:0]        LivesInit = 2'(LIVES_INIT);
    localparam logic [1:0]        MaxLevel  = 2'(MAX_LEVEL);
    localparam logic [DivW-1:0]   DivInit   = DivW'(STEP_DIV_INIT);
    localparam logic [PauseW-1:0] PauseLast = PauseW'(PAUSE_TICKS - 1);

    typedef enum logic [2:0] {
        StClear   = 3'd0,
        StServe   = 3'd1,
        StPlay    = 3'd2,
        StLost    = 3'd3,
        StCleared = 3'd4,
        StOver    = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          lives_q, lives_d;
    logic [7:0]          score_q, score_d;
    logic [1:0]          level_q, level_d;
    logic [DivW-1:0]     step_div_q, step_div_d;
    logic [DivW-1:0]     step_cnt_q, step_cnt_d;
    logic [PauseW-1:0]   pause_cnt_q, pause_cnt_d;
    logic                throw_prev_q;
    logic                engine_clr_q, engine_clr_d;
    logic                serve_rst_q, serve_rst_d;
    logic                serve_hold_q, serve_hold_d;
    logic                ball_step_q, ball_step_d;
    logic                game_over_q, game_over_d;

    logic                throw_edge;
    logic                step_wrap;
    logic [7:0]          score_inc;
    logic [1:0]          level_inc;
    logic [DivW-1:0]     div_new;

    assign throw_edge = throw_btn_i & ~throw_prev_q;
    assign level_inc  = (level_q >= MaxLevel) ? level_q : level_q + 2'd1;

    // Two-digit BCD increment, saturating at 99.
    always_comb begin
        if (score_q == 8'h99) begin
            score_inc = score_q;
        end else if (score_q[3:0] == 4'd9) begin
            score_inc = {score_q[7:4] + 4'd1, 4'd0};
        end else begin
            score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
        end
    end

    always_comb begin
        div_new = DivW'(STEP_DIV_MIN);
        if (STEP_DIV_INIT >= 32'(level_inc) + STEP_DIV_MIN) begin
            div_new = DivW'(STEP_DIV_INIT - 32'(level_inc));
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        level_d     = level_q;
        step_div_d  = step_div_q;
        step_cnt_d  = step_cnt_q;
        pause_cnt_d = pause_cnt_q;
        serve_rst_d = 1'b0;
        step_wrap   = 1'b0;

        case (state_q)
            StClear: state_d = StServe;
            StServe: begin
                if (throw_edge) begin
                    state_d    = StPlay;
                    step_cnt_d = '0;
                end
            end
            StPlay: begin
                if (tick_i) begin
                    if (step_cnt_q == step_div_q - 1'b1) begin
                        step_cnt_d = '0;
                        step_wrap  = 1'b1;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                if (brick_hit_i) begin
                    score_d = score_inc;
                end
                // An emptied wall wins over a simultaneous ball loss.
                if (bricks_left_i == 5'd0) begin
                    state_d     = StCleared;
                    level_d     = level_inc;
                    step_div_d  = div_new;
                    pause_cnt_d = '0;
                end else if (ball_lost_i) begin
                    state_d     = StLost;
                    lives_d     = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
                    pause_cnt_d = '0;
                    serve_rst_d = 1'b1;
                end
            end
            StLost: begin
                if (tick_i) begin
                    if (pause_cnt_q == PauseLast) begin
                        state_d = (lives_q == 2'd0) ? StOver : StServe;
                    end else begin
                        pause_cnt_d = pause_cnt_q + 1'b1;
                    end
                end
            end
            StCleared: begin
                if (tick_i) begin
                    if (pause_cnt_q == PauseLast) begin
                        state_d = StClear;
                    end else begin
                        pause_cnt_d = pause_cnt_q + 1'b1;
                    end
                end
            end
            StOver: begin
                if (throw_edge) begin
                    state_d    = StClear;
                    lives_d    = LivesInit;
                    score_d    = 8'h00;
                    level_d    = 2'd0;
                    step_div_d = DivInit;
                end
            end
            default: state_d = StClear;
        endcase

        engine_clr_d = (state_q == StClear);
        serve_hold_d = (state_d == StServe);
        game_over_d  = (state_d == StOver);
        // A tick that coincides with leaving PLAY must not move the ball.
        ball_step_d  = step_wrap & (state_d == StPlay);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StClear;
            lives_q      <= LivesInit;
            score_q      <= 8'h00;
            level_q      <= 2'd0;
            step_div_q   <= DivInit;
            step_cnt_q   <= '0;
            pause_cnt_q  <= '0;
            throw_prev_q <= 1'b1;
            engine_clr_q <= 1'b0;
            serve_rst_q  <= 1'b0;
            serve_hold_q <= 1'b0;
            ball_step_q  <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            level_q      <= level_d;
            step_div_q   <= step_div_d;
            step_cnt_q   <= step_cnt_d;
            pause_cnt_q  <= pause_cnt_d;
            throw_prev_q <= throw_btn_i;
            engine_clr_q <= engine_clr_d;
            serve_rst_q  <= serve_rst_d;
            serve_hold_q <= serve_hold_d;
            ball_step_q  <= ball_step_d;
            game_over_q  <= game_over_d;
        end
    end

    assign engine_clr_o = engine_clr_q;
    assign serve_rst_o  = serve_rst_q;
    assign serve_hold_o = serve_hold_q;
    assign ball_step_o  = ball_step_q;
    assign lives_o      = lives_q;
    assign score_o      = score_q;
    assign level_o      = level_q;
    assign state_o      = state_q;
    assign game_over_o  = game_over_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Game-level sequencer for the 8x8 LED brick-breaker datapath (ball/paddle/brick engine plus scan display).
- Owns the game state machine: brick reload, serve hold, ball step pacing, lives, score and level/speed progression.
- The engine reports events (brick hit, ball lost, bricks remaining); this block returns control strobes and display values.
- Runs on the system clock; all engine timing is qualified by a single-cycle game tick.

Parameters:
LIVES_INIT, 3, lives loaded at reset and at game restart (1..3)
STEP_DIV_INIT, 3, game ticks per ball step at level 0
STEP_DIV_MIN, 1, minimum ticks per ball step
PAUSE_TICKS, 20, ticks spent in the LOST and CLEARED pause states (1 s at 20 Hz)
MAX_LEVEL, 3, level saturation value

Ports:
CLK  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle game tick enable (20 Hz)
throw_btn  in  1  throw/start button, level, pre-synchronised
brick_hit  in  1  one-cycle pulse from the engine, brick destroyed
ball_lost  in  1  one-cycle pulse from the engine, ball fell below the paddle
bricks_left  in  5  bricks remaining, 0..16
engine_clr  out  1  reload all bricks and reset paddle/ball positions
serve_rst  out  1  one-cycle pulse: re-centre paddle and ball, bricks kept
serve_hold  out  1  ball rides the paddle
ball_step  out  1  one-cycle pulse: advance ball one position
lives  out  2  remaining lives
score  out  8  two-digit BCD {tens, units}
level  out  2  current level
state  out  3  encoded FSM state for debug LEDs
game_over  out  1  high in OVER

Behaviour:
- All outputs are registered. While `reset` is low: state=CLEAR, lives=LIVES_INIT, score=8'h00, level=0, step_div=STEP_DIV_INIT, step_cnt=0, pause_cnt=0, throw_prev=1, and all strobes, serve_hold and game_over are 0.
- throw_prev resets to 1, so a button held through reset release gives no serve. A throw edge is `throw_btn & ~throw_prev`, evaluated every CLK.
- State encoding: CLEAR=0, SERVE=1, PLAY=2, LOST=3, CLEARED=4, OVER=5. Codes 6 and 7 go to CLEAR.
- CLEAR:
  - engine_clr=1 for exactly one cycle.
  - Next state SERVE.
- SERVE:
  - serve_hold=1.
  - On a throw edge: next state PLAY, step_cnt=0.
  - brick_hit and ball_lost are ignored.
- PLAY:
  - Each tick increments step_cnt. When step_cnt==step_div-1 on a tick, step_cnt returns to 0 and ball_step pulses the following cycle.
  - step_cnt only changes on tick cycles.
  - brick_hit: score +1 in BCD (units 9 to 0 with tens carry), saturating at 8'h99.
  - Event priority in the same cycle:
    1. bricks_left==0 goes to CLEARED, even if ball_lost is also asserted.
    2. Otherwise ball_lost goes to LOST.
  - A brick_hit in the same cycle as a transition is still scored.
- LOST:
  - On entry lives decrements, never below 0. serve_rst pulses once on entry.
  - pause_cnt counts ticks; after PAUSE_TICKS ticks, go to OVER if lives==0, else SERVE.
- CLEARED:
  - On entry level increments, saturating at MAX_LEVEL.
  - step_div = max(STEP_DIV_INIT - new_level, STEP_DIV_MIN).
  - After PAUSE_TICKS ticks, go to CLEAR (bricks reload).
- OVER:
  - game_over=1. Events are ignored.
  - On a throw edge: lives=LIVES_INIT, score=0, level=0, step_div=STEP_DIV_INIT, then go to CLEAR.
- Pause counter: pause_cnt is cleared whenever LOST or CLEARED is entered, so it never carries over between pauses.
- Reset mid-operation: asynchronous return to the reset values. Any strobe in flight is cancelled that cycle.
- ball_step is never asserted outside PLAY. A tick coinciding with the PLAY exit produces no step.

Test Plan:
1. Reset release with throw_btn low → 1 cycle engine_clr=1, then state=1 and serve_hold=1. Raise throw_btn → state=2. With tick every 4 CLK, ball_step pulses every 3rd tick.
2. In PLAY, pulse brick_hit 12 times → score=8'h12. Preload score 8'h98 and pulse 3 more → score=8'h99 (saturated).
3. ball_lost in PLAY → lives 3→2 and a single serve_rst pulse. After 20 ticks state=1. Repeat twice → lives=0, state=5, game_over=1. A throw edge → lives=3, score=0, engine_clr pulse.
4. Same cycle bricks_left=0 and ball_lost=1 → state=4 and lives unchanged. After 20 ticks, engine_clr pulses, level=1 and ball_step period becomes 2 ticks. Repeat to level 3 → period 1 tick; a further clear keeps level=3.
5. Hold throw_btn high through reset release → state stays 1 until the button is released and pressed again.
6. Assert reset mid-PLAY while step_cnt=1 → outputs return immediately to reset values, with no ball_step in the reset cycle.
